// File: rtl/dm_pipe_be.sv
// dm_pipe_be: word-organised byte/half/word data memory with a one-cycle registered response
// and sticky error capture. Define DM_MISALIGN_SPLIT_EN to split misaligned half/word accesses.
module dm_pipe_be #(
  parameter int ADDR_W    = 10,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              err_sticky,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clr
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  // NOTE: storage is filled once by its declaration and deliberately excluded from reset.
  logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

  logic             op_we, op_unsigned;
  logic [1:0]       op_size, op_off;
  logic [IDX_W-1:0] op_idx;
  logic [31:0]      op_wdata;
  logic             accept, misaligned, req_err, rsp_fire;
  logic [3:0]       size_mask, be_lo;
  logic [31:0]      wd_lo, rd_raw, rd_ext;

  assign accept     = req_valid && req_ready;
  assign misaligned = (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);

`ifdef DM_MISALIGN_SPLIT_EN
  typedef enum logic {IDLE, SECOND} state_t;
  state_t           state_q, state_d;
  logic             in_second;
  logic             sv_we, sv_unsigned;
  logic [1:0]       sv_size, sv_off;
  logic [IDX_W-1:0] sv_idx, idx_nx;
  logic [31:0]      sv_wdata, wd_hi;
  logic [3:0]       be_hi;

  assign req_err   = (req_size == 2'b11);
  assign req_ready = (state_q == IDLE);
  assign in_second = (state_q == SECOND);
  assign rsp_fire  = (accept && !misaligned) || in_second;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && misaligned) state_d = SECOND;
      SECOND:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The second half replays the accepted request from these registers.
  always_ff @(posedge clk) begin
    if (accept && misaligned) begin
      sv_we       <= req_we;
      sv_unsigned <= req_unsigned;
      sv_size     <= req_size;
      sv_off      <= req_addr[1:0];
      sv_idx      <= req_addr[ADDR_W-1:2];
      sv_wdata    <= req_wdata;
    end
  end

  assign op_we       = in_second ? sv_we       : req_we;
  assign op_unsigned = in_second ? sv_unsigned : req_unsigned;
  assign op_size     = in_second ? sv_size     : req_size;
  assign op_off      = in_second ? sv_off      : req_addr[1:0];
  assign op_idx      = in_second ? sv_idx      : req_addr[ADDR_W-1:2];
  assign op_wdata    = in_second ? sv_wdata    : req_wdata;
  assign idx_nx      = op_idx + 1'b1;

  // Bytes that spill past lane 3 land in the next word, which wraps at the top.
  assign be_hi  = size_mask >> (3'd4 - {1'b0, op_off});
  assign wd_hi  = op_wdata >> {3'd4 - {1'b0, op_off}, 3'b0};
  assign rd_raw = (mem[op_idx] >> {op_off, 3'b0}) |
                  (mem[idx_nx] << {3'd4 - {1'b0, op_off}, 3'b0});
`else
  assign req_err     = (req_size == 2'b11) || misaligned;
  assign req_ready   = 1'b1;
  assign rsp_fire    = accept;
  assign op_we       = req_we;
  assign op_unsigned = req_unsigned;
  assign op_size     = req_size;
  assign op_off      = req_addr[1:0];
  assign op_idx      = req_addr[ADDR_W-1:2];
  assign op_wdata    = req_wdata;
  assign rd_raw      = mem[op_idx] >> {op_off, 3'b0};
`endif

  always_comb begin
    size_mask = 4'b0000;
    case (op_size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  end

  assign be_lo = size_mask << op_off;
  assign wd_lo = op_wdata << {op_off, 3'b0};

  always_comb begin
    rd_ext = rd_raw;
    case (op_size)
      2'b00:   rd_ext = op_unsigned ? {24'h0, rd_raw[7:0]} : {{24{rd_raw[7]}}, rd_raw[7:0]};
      2'b01:   rd_ext = op_unsigned ? {16'h0, rd_raw[15:0]} : {{16{rd_raw[15]}}, rd_raw[15:0]};
      default: rd_ext = rd_raw;
    endcase
  end

  // Stores commit at the accept edge, so a following load needs no bypass.
  always_ff @(posedge clk) begin
    if (rst_n && accept && req_we && !req_err) begin
      for (int b = 0; b < 4; b++)
        if (be_lo[b]) mem[op_idx][8*b +: 8] <= wd_lo[8*b +: 8];
    end
`ifdef DM_MISALIGN_SPLIT_EN
    if (rst_n && in_second && op_we) begin
      for (int b = 0; b < 4; b++)
        if (be_hi[b]) mem[idx_nx][8*b +: 8] <= wd_hi[8*b +: 8];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end else begin
      rsp_valid <= rsp_fire;
      rsp_err   <= accept && req_err;
      rsp_rdata <= (rsp_fire && !(accept && req_err) && !op_we) ? rd_ext : '0;
      // A new error beats a simultaneous clear.
      if (accept && req_err) begin
        err_sticky <= 1'b1;
        if (!err_sticky || err_clr) err_addr <= req_addr;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
        err_addr   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dm_pipe_be.sv
// tb_dm_pipe_be: directed table-driven bench for dm_pipe_be plus hand-written error,
// reset and (with DM_MISALIGN_SPLIT_EN) split-access sequences.
module tb_dm_pipe_be;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, err_clr = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_err, err_sticky;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] err_addr;

  int checks = 0;
  int errors = 0;

`ifdef DM_MISALIGN_SPLIT_EN
  localparam logic [1:0] BAD_W = 2'b11;
  localparam logic [1:0] BAD_H = 2'b11;
`else
  localparam logic [1:0] BAD_W = 2'b10;
  localparam logic [1:0] BAD_H = 2'b01;
`endif

  dm_pipe_be #(.ADDR_W(AW), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .err_sticky(err_sticky), .err_addr(err_addr),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [AW-1:0] addr, input logic [31:0] wdata, input logic clr);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    err_clr      = clr;
    req_valid    = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // we, size, uns, addr, wdata, expected rdata
    vecs.push_back('{1'b0, 2'b10, 1'b0, 10'h040, 32'h0,         32'h0000_0000});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 10'h010, 32'h8765_43A1, 32'h0000_0000});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 10'h010, 32'h0,         32'hFFFF_FFA1});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 10'h013, 32'h0,         32'h0000_0087});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 10'h012, 32'h0,         32'hFFFF_8765});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 10'h012, 32'h0,         32'h0000_8765});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 10'h011, 32'hFFFF_FF5A, 32'h0000_0000});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 10'h010, 32'h0,         32'h8765_5AA1});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 10'h01A, 32'h1234_BEEF, 32'h0000_0000});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 10'h01A, 32'h0,         32'hFFFF_BEEF});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 10'h01B, 32'h0,         32'hFFFF_FFBE});
    vecs.push_back('{1'b0, 2'b10, 1'b1, 10'h018, 32'h0,         32'hBEEF_0000});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 10'h3FC, 32'hCAFE_F00D, 32'h0000_0000});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0,         32'hCAFE_F00D});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 10'h3FF, 32'h0,         32'h0000_00CA});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 10'h3FC, 32'h0,         32'h0000_F00D});

    // Reset held two cycles with a store pending: nothing may be written or answered.
    rst_n = 1'b0;
    drive(1'b1, 2'b10, 1'b0, 10'h040, 32'h1122_3344, 1'b0);
    step();
    step();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err_sticky", err_sticky, 0);
    rst_n = 1'b1;
    req_valid = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_err_addr", err_addr, 0);

    // Back-to-back table: each vector is accepted on consecutive edges.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, 1'b0);
      step();
      check($sformatf("vec%0d_valid", i), rsp_valid, 1);
      check($sformatf("vec%0d_err", i), rsp_err, 0);
      check($sformatf("vec%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
    end
    req_valid = 1'b0;
    step();
    check("rsp_not_held", rsp_valid, 0);

    // Error capture, sticky address and clear priority.
    drive(1'b1, BAD_W, 1'b0, 10'h021, 32'hAAAA_AAAA, 1'b0);
    step();
    req_valid = 1'b0;
    check("err1_valid", rsp_valid, 1);
    check("err1_rsp_err", rsp_err, 1);
    check("err1_rdata", rsp_rdata, 0);
    check("err1_sticky", err_sticky, 1);
    check("err1_addr", err_addr, 10'h021);

    drive(1'b0, BAD_H, 1'b0, 10'h033, 32'h0, 1'b0);
    step();
    req_valid = 1'b0;
    check("err2_rsp_err", rsp_err, 1);
    check("err2_addr_kept", err_addr, 10'h021);

    drive(1'b0, BAD_W, 1'b0, 10'h045, 32'h0, 1'b1);
    step();
    req_valid = 1'b0;
    err_clr = 1'b0;
    check("err3_sticky", err_sticky, 1);
    check("err3_addr_new", err_addr, 10'h045);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_sticky", err_sticky, 0);
    check("clr_addr", err_addr, 0);
    check("clr_no_rsp", rsp_valid, 0);

    drive(1'b0, 2'b11, 1'b1, 10'h014, 32'h0, 1'b0);
    step();
    check("rsv_rsp_err", rsp_err, 1);
    check("rsv_rdata", rsp_rdata, 0);
    check("rsv_addr", err_addr, 10'h014);

    drive(1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 1'b0);
    step();
    req_valid = 1'b0;
    check("no_err_write_valid", rsp_valid, 1);
    check("no_err_write_err", rsp_err, 0);
    check("no_err_write_rdata", rsp_rdata, 0);

`ifdef DM_MISALIGN_SPLIT_EN
    // Misaligned word store wrapping from the top word into word 0.
    drive(1'b1, 2'b10, 1'b0, 10'h3FE, 32'hDEAD_BEEF, 1'b0);
    step();
    req_valid = 1'b0;
    check("split_st_ready_low", req_ready, 0);
    check("split_st_no_early", rsp_valid, 0);
    step();
    check("split_st_valid", rsp_valid, 1);
    check("split_st_err", rsp_err, 0);
    check("split_st_ready", req_ready, 1);

    drive(1'b0, 2'b10, 1'b0, 10'h3FE, 32'h0, 1'b0);
    step();
    req_valid = 1'b0;
    check("split_ld_no_early", rsp_valid, 0);
    step();
    check("split_ld_valid", rsp_valid, 1);
    check("split_ld_rdata", rsp_rdata, 32'hDEAD_BEEF);

    drive(1'b0, 2'b01, 1'b1, 10'h3FF, 32'h0, 1'b0);
    step();
    req_valid = 1'b0;
    step();
    check("split_half_rdata", rsp_rdata, 32'h0000_ADBE);

    drive(1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0, 1'b0);
    step();
    check("split_top_word", rsp_rdata, 32'hBEEF_F00D);
    drive(1'b0, 2'b10, 1'b0, 10'h000, 32'h0, 1'b0);
    step();
    req_valid = 1'b0;
    check("split_word0", rsp_rdata, 32'h0000_DEAD);

    // Reset lands while the second half is pending.
    drive(1'b1, 2'b10, 1'b0, 10'h3FE, 32'h1122_3344, 1'b0);
    step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check("split_rst_no_rsp", rsp_valid, 0);
    rst_n = 1'b1;
    #1;
    check("split_rst_ready", req_ready, 1);
    drive(1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0, 1'b0);
    step();
    check("split_rst_first", rsp_rdata, 32'h3344_F00D);
    drive(1'b0, 2'b10, 1'b0, 10'h000, 32'h0, 1'b0);
    step();
    req_valid = 1'b0;
    check("split_rst_second", rsp_rdata, 32'h0000_DEAD);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
